// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default timing constants and
// parity modes used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_mode_e;

  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_BAUD_DIV   = 651;  // 100 MHz / (9600 * 16)

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/baud_rate_generator.sv
// Free-running sample-tick generator; clear realigns the tick phase so a new
// frame's first bit is exactly one full bit period long.
module baud_rate_generator
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic sample_tick
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign sample_tick = (count_q == CNT_LAST);

  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || sample_tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pops words from a first-word-fall-through FIFO and
// frames each one as start, LSB-first data, optional parity and stop.
module uart_tx_fifo_reader
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int SB_TICKS   = 16,
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_enable,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  localparam int TICK_MAX = max_int(OVERSAMPLE, SB_TICKS);
  localparam int TICK_W   = max_int(1, $clog2(TICK_MAX));
  localparam int BIT_W    = max_int(1, $clog2(DATA_BITS));

  localparam logic [TICK_W-1:0] OS_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] SB_LAST  = TICK_W'(SB_TICKS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

  localparam parity_mode_e PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  uart_state_e          state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;

  logic                 sample_tick;
  logic                 start_frame;
  logic                 period_end;
  logic                 done;
  logic [TICK_W-1:0]    period_last;

  // Reset gates the pop so a word is never taken on a cycle whose state
  // update is discarded.
  assign start_frame = (state_q == ST_IDLE) && tx_enable && !fifo_empty && !reset;

  baud_rate_generator #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk         (clk),
    .reset       (reset),
    .clear       (start_frame),
    .sample_tick (sample_tick)
  );

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    done     = 1'b0;

    period_last = (state_q == ST_STOP) ? SB_LAST : OS_LAST;
    period_end  = sample_tick && (tick_q == period_last);

    if ((state_q != ST_IDLE) && sample_tick) begin
      tick_d = period_end ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_frame) begin
          shift_d  = fifo_data;
          parity_d = (^fifo_data) ^ (PAR_MODE == PAR_ODD);
          tick_d   = '0;
          bit_d    = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (period_end) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (period_end) begin
          if (bit_q == BIT_LAST) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (period_end) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (period_end) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level is computed from the next state so the registered tx lines
    // up with the state it belongs to.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

  assign fifo_read    = start_frame;
  assign tx           = tx_q;
  assign tx_busy      = (state_q != ST_IDLE);
  assign tx_done_tick = done && !reset;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Three transmitter configurations driven from FIFO models; a per-lane line
// monitor decodes every frame and compares it against a scoreboard queue.
module tb_uart_tx_fifo_reader;

  localparam int NL = 3;
  localparam int OS = 16;
  localparam int BD [NL] = '{4, 4, 3};
  localparam int DB [NL] = '{8, 8, 6};
  localparam int PE [NL] = '{0, 1, 1};
  localparam int PO [NL] = '{0, 1, 0};
  localparam int SB [NL] = '{16, 32, 24};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NL-1:0] tx_enable  = '0;
  logic [NL-1:0] fifo_empty = '1;
  logic [7:0]    fifo_data [NL];
  wire  [NL-1:0] fifo_read, tx, tx_busy, tx_done_tick;

  uart_tx_fifo_reader #(.DATA_BITS(8), .OVERSAMPLE(OS), .SB_TICKS(16), .BAUD_DIV(4),
                        .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .reset(reset), .tx_enable(tx_enable[0]), .fifo_empty(fifo_empty[0]),
    .fifo_data(fifo_data[0]), .fifo_read(fifo_read[0]), .tx(tx[0]),
    .tx_busy(tx_busy[0]), .tx_done_tick(tx_done_tick[0]));

  uart_tx_fifo_reader #(.DATA_BITS(8), .OVERSAMPLE(OS), .SB_TICKS(32), .BAUD_DIV(4),
                        .PARITY_EN(1), .PARITY_ODD(1)) u_dut1 (
    .clk(clk), .reset(reset), .tx_enable(tx_enable[1]), .fifo_empty(fifo_empty[1]),
    .fifo_data(fifo_data[1]), .fifo_read(fifo_read[1]), .tx(tx[1]),
    .tx_busy(tx_busy[1]), .tx_done_tick(tx_done_tick[1]));

  uart_tx_fifo_reader #(.DATA_BITS(6), .OVERSAMPLE(OS), .SB_TICKS(24), .BAUD_DIV(3),
                        .PARITY_EN(1), .PARITY_ODD(0)) u_dut2 (
    .clk(clk), .reset(reset), .tx_enable(tx_enable[2]), .fifo_empty(fifo_empty[2]),
    .fifo_data(fifo_data[2][5:0]), .fifo_read(fifo_read[2]), .tx(tx[2]),
    .tx_busy(tx_busy[2]), .tx_done_tick(tx_done_tick[2]));

  logic [7:0] fq    [NL][$];
  logic [7:0] exp_q [NL][$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  int   pops [NL];
  int   starts [NL];
  int   stray_pop [NL];
  int   stray_done [NL];
  int   gap [NL];
  int   last_pop_cyc [NL];
  int   last_done_cyc [NL];
  logic pop_en [NL];
  logic mon_active [NL];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int bit_period(input int l);
    return OS * BD[l];
  endfunction

  function automatic int frame_len(input int l);
    return BD[l] * (OS * (1 + DB[l] + PE[l]) + SB[l]);
  endfunction

  task automatic refresh(input int l);
    fifo_empty[l] = (fq[l].size() == 0);
    fifo_data[l]  = (fq[l].size() != 0) ? fq[l][0] : 8'h00;
  endtask

  task automatic push(input int l, input logic [7:0] w);
    logic [7:0] m;
    m = 8'((1 << DB[l]) - 1);
    fq[l].push_back(w & m);
    exp_q[l].push_back(w & m);
    refresh(l);
  endtask

  // FIFO model: pop strobes are sampled mid-cycle and applied after the edge.
  initial begin
    logic [NL-1:0] pend;
    forever begin
      @(negedge clk);
      pend = fifo_read;
      for (int l = 0; l < NL; l++) begin
        if (pend[l]) begin
          pops[l]++;
          last_pop_cyc[l] = cyc;
          pop_en[l] = tx_enable[l];
          if (fifo_empty[l]) stray_pop[l]++;
        end
      end
      @(posedge clk);
      #1;
      for (int l = 0; l < NL; l++) begin
        if (pend[l] && fq[l].size() != 0) begin
          void'(fq[l].pop_front());
          refresh(l);
        end
      end
    end
  end

  // Line monitor: checks every cycle of a frame against the ideal waveform.
  task automatic monitor(input int l);
    int cnt, bp, fl, nb, terr;
    logic [10:0] bits;
    logic [7:0] w, dec;
    logic lvl;
    bp = bit_period(l);
    fl = frame_len(l);
    nb = 1 + DB[l] + PE[l];
    cnt = 0; terr = 0; w = '0; dec = '0; bits = '1;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_active[l] = 1'b0;
        continue;
      end
      if (!mon_active[l]) begin
        if (tx_done_tick[l]) stray_done[l]++;
        if (!tx[l]) begin
          mon_active[l] = 1'b1;
          cnt = 0; terr = 0; dec = '0;
          starts[l]++;
          gap[l] = cyc - last_done_cyc[l];
          if (last_pop_cyc[l] != cyc - 1 || !pop_en[l]) terr++;
          if (exp_q[l].size() == 0) begin
            check($sformatf("lane%0d unexpected frame", l), 1, 0);
            w = '0;
          end else begin
            w = exp_q[l].pop_front();
          end
          bits = '1;
          bits[0] = 1'b0;
          for (int k = 0; k < DB[l]; k++) bits[1 + k] = w[k];
          if (PE[l] != 0) bits[1 + DB[l]] = (^w) ^ (PO[l] != 0);
        end
      end
      if (mon_active[l]) begin
        if (cnt == fl) begin
          if (tx_busy[l] || !tx[l] || tx_done_tick[l]) terr++;
          check($sformatf("lane%0d frame data", l), int'(dec), int'(w));
          check($sformatf("lane%0d frame timing errors", l), terr, 0);
          mon_active[l] = 1'b0;
        end else begin
          lvl = (cnt < nb * bp) ? bits[cnt / bp] : 1'b1;
          if (tx[l] != lvl) terr++;
          if (!tx_busy[l]) terr++;
          if (tx_done_tick[l] != (cnt == fl - 1)) terr++;
          if (cnt == fl - 1) last_done_cyc[l] = cyc;
          if ((cnt % bp) == bp / 2 && cnt / bp >= 1 && cnt / bp <= DB[l])
            dec[cnt / bp - 1] = tx[l];
          cnt++;
        end
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    logic busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < 40000) begin
      @(negedge clk);
      #1;
      n++;
      busy = 1'b0;
      for (int l = 0; l < NL; l++)
        if (exp_q[l].size() != 0 || fq[l].size() != 0 || mon_active[l]) busy = 1'b1;
    end
    check(name, int'(busy), 0);
  endtask

  initial begin
    int low_cnt, rd_cnt, pushed, n;
    logic started;
    for (int l = 0; l < NL; l++) begin
      pops[l] = 0; starts[l] = 0; stray_pop[l] = 0; stray_done[l] = 0;
      gap[l] = 0; last_pop_cyc[l] = -100; last_done_cyc[l] = -100;
      pop_en[l] = 1'b0; mon_active[l] = 1'b0;
      refresh(l);
    end
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none

    // Reset with data present and transmit enabled: nothing may move.
    push(0, 8'hA5);
    push(1, 8'hA5);
    tx_enable = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset tx", int'(tx), 7);
    check("reset tx_busy", int'(tx_busy), 0);
    check("reset tx_done_tick", int'(tx_done_tick), 0);
    check("reset fifo_read", int'(fifo_read), 0);

    // Disabled with data waiting (lanes 0,1) and empty (lane 2).
    @(posedge clk); #1;
    reset = 1'b0;
    tx_enable = '0;
    low_cnt = 0; rd_cnt = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx != '1) low_cnt++;
      if (fifo_read != '0) rd_cnt++;
    end
    check("idle tx low cycles", low_cnt, 0);
    check("idle fifo_read cycles", rd_cnt, 0);

    @(posedge clk); #1;
    tx_enable = '1;
    started = 1'b0;
    for (int i = 0; i < 2 && !started; i++) begin
      @(negedge clk);
      started = !tx[0];
    end
    check("start within 2 clocks", int'(started), 1);
    wait_drain("drain directed 0xA5");

    // Back-to-back frames on lane 0.
    @(posedge clk); #1;
    push(0, 8'h00);
    push(0, 8'hFF);
    wait_drain("drain back-to-back");
    check("back-to-back start after done", gap[0], 2);

    // Randomized traffic with tx_enable toggling mid-frame.
    pushed = 0;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk); #1;
      if (pushed < 30 && $urandom_range(0, 99) == 0) begin
        push(int'($urandom_range(0, NL - 1)), 8'($urandom));
        pushed++;
      end
      if ($urandom_range(0, 299) == 0) begin
        n = int'($urandom_range(0, NL - 1));
        tx_enable[n] = ~tx_enable[n];
      end
    end
    @(posedge clk); #1;
    tx_enable = '1;
    wait_drain("drain random traffic");

    // Reset during data bit 3 of lane 0; all lanes are mid-frame.
    @(posedge clk); #1;
    for (int l = 0; l < NL; l++) push(l, 8'($urandom));
    n = 0;
    while (tx[0] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reset-test frame start", int'(n < 2000), 1);
    repeat (4 * bit_period(0) + 10) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid-frame reset tx", int'(tx), 7);
    check("mid-frame reset tx_busy", int'(tx_busy), 0);
    for (int l = 0; l < NL; l++) exp_q[l].delete();
    @(posedge clk); #1;
    push(0, 8'h3C);
    push(1, 8'hC3);
    push(2, 8'h2B);
    wait_drain("drain after reset");

    for (int l = 0; l < NL; l++) begin
      check($sformatf("lane%0d stray done ticks", l), stray_done[l], 0);
      check($sformatf("lane%0d pops while empty", l), stray_pop[l], 0);
      check($sformatf("lane%0d pops vs frames", l), pops[l], starts[l]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
